// File: rtl/dbus_mux_if.sv
// Request/response bundle for the core data bus; the same shape serves the
// master side and both slave ports, with the address width set per instance.
interface dbus_mux_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            req;
    logic            write;
    logic [DW/8-1:0] wstrb;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic            addr_ok;
    logic            data_ok;
    logic [DW-1:0]   rdata;

    modport master (
        output req, write, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, write, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/dbus_mux.sv
// Data-bus router: one master to RAM and MMIO, with in-order read returns.
// Define DBUS_DECERR_EN to answer unmapped addresses locally and add dec_err.
module dbus_mux #(
    parameter int          DW        = 32,
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter int          MMIO_AW   = 16,
    parameter int          MAX_OUT   = 2
) (
    input  logic       clk,
    input  logic       rst_b,
    dbus_mux_if.slave  m,
    dbus_mux_if.master ram,
    dbus_mux_if.master io
`ifdef DBUS_DECERR_EN
    ,
    output logic       dec_err
`endif
);
    typedef enum logic [1:0] {
        TGT_RAM = 2'd0,
        TGT_IO  = 2'd1,
        TGT_ERR = 2'd2
    } tgt_e;

    localparam logic [32:0] RAM_SPAN = 33'd4 << RAM_AW;
    localparam logic [2:0]  CNT_MAX  = 3'(MAX_OUT);

    logic [2:0]  cnt;
    tgt_e        tgt;
    tgt_e        dec;
    logic        err_ret;
    logic [31:0] ram_off;
    logic        in_ram;
    logic        tgt_data_ok;
    logic        sel_addr_ok;
    logic        ret;
    logic        stall;
    logic        acc_rd;

    // Offset compare wraps below the base, so one test covers both bounds.
    assign ram_off = m.addr - RAM_BASE;
    assign in_ram  = ({1'b0, ram_off} < RAM_SPAN);

`ifdef DBUS_DECERR_EN
    localparam logic [32:0] MMIO_SPAN = 33'd1 << MMIO_AW;
    logic [31:0] io_off;
    logic        in_io;
    assign io_off = m.addr - MMIO_BASE;
    assign in_io  = ({1'b0, io_off} < MMIO_SPAN);
`endif

    always_comb begin
        dec = TGT_IO;
        if (in_ram) begin
            dec = TGT_RAM;
        end
`ifdef DBUS_DECERR_EN
        else if (!in_io) begin
            dec = TGT_ERR;
        end
`endif
    end

    always_comb begin
        case (tgt)
            TGT_RAM: tgt_data_ok = ram.data_ok;
            TGT_IO:  tgt_data_ok = io.data_ok;
            default: tgt_data_ok = err_ret;
        endcase
    end

    always_comb begin
        case (dec)
            TGT_RAM: sel_addr_ok = ram.addr_ok;
            TGT_IO:  sel_addr_ok = io.addr_ok;
            default: sel_addr_ok = 1'b1;
        endcase
    end

    always_comb begin
        case (tgt)
            TGT_RAM: m.rdata = ram.rdata;
            TGT_IO:  m.rdata = io.rdata;
            default: m.rdata = DW'(32'hDEAD_BEEF);
        endcase
    end

    // Returns with nothing pending, or from the other slave, are stale and dropped.
    assign ret   = (cnt != 3'd0) && tgt_data_ok;
    assign stall = m.req && (((cnt != 3'd0) && (dec != tgt)) ||
                             (!m.write && (cnt == CNT_MAX) && !ret));

    assign m.addr_ok = sel_addr_ok && !stall;
    assign m.data_ok = ret;
    assign acc_rd    = m.req && !m.write && m.addr_ok;

    assign ram.req   = m.req && (dec == TGT_RAM) && !stall;
    assign ram.write = m.write;
    assign ram.wstrb = m.wstrb;
    assign ram.wdata = m.wdata;
    assign ram.addr  = m.addr[RAM_AW+1:2];

    assign io.req    = m.req && (dec == TGT_IO) && !stall;
    assign io.write  = m.write;
    assign io.wstrb  = m.wstrb;
    assign io.wdata  = m.wdata;
    assign io.addr   = m.addr[MMIO_AW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cnt     <= 3'd0;
            tgt     <= TGT_RAM;
            err_ret <= 1'b0;
`ifdef DBUS_DECERR_EN
            dec_err <= 1'b0;
`endif
        end else begin
            if (acc_rd && !ret) begin
                cnt <= cnt + 3'd1;
            end else if (ret && !acc_rd) begin
                cnt <= cnt - 3'd1;
            end
            if (acc_rd) begin
                tgt <= dec;
            end
            // An unmapped read is answered locally on the following cycle.
            err_ret <= acc_rd && (dec == TGT_ERR);
`ifdef DBUS_DECERR_EN
            dec_err <= m.req && m.addr_ok && (dec == TGT_ERR);
`endif
        end
    end
endmodule

// File: tb/tb_dbus_mux.sv
// Directed literal checks followed by randomized traffic against a queue-based
// model of the router (address map, outstanding-read limit, in-order returns).
module tb_dbus_mux;
    localparam int MAX_OUT = 2;
    localparam int T_RAM = 0;
    localparam int T_IO  = 1;
    localparam int T_ERR = 2;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    dbus_mux_if #(.AW(32), .DW(32)) m_bus ();
    dbus_mux_if #(.AW(12), .DW(32)) ram_bus ();
    dbus_mux_if #(.AW(16), .DW(32)) io_bus ();
`ifdef DBUS_DECERR_EN
    logic dec_err;
`endif

    dbus_mux #(.MAX_OUT(MAX_OUT)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .m     (m_bus),
        .ram   (ram_bus),
        .io    (io_bus)
`ifdef DBUS_DECERR_EN
        ,
        .dec_err (dec_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    // master-side model: pending reads in issue order
    int          pq_tgt[$];
    logic [31:0] pq_dat[$];
    int          last_tgt;
    bit          err_due;
    bit          dec_err_exp;
    int          m_ram_seq;
    int          m_io_seq;
    bit          mst_busy;

    // slave behaviour: accepted reads with remaining latency
    logic [31:0] rq_d[$];
    int          rq_w[$];
    logic [31:0] iq_d[$];
    int          iq_w[$];
    bit          r_pop;
    bit          i_pop;
    int          s_ram_seq;
    int          s_io_seq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic int region(input logic [31:0] a);
        if (a < 32'h0000_4000) return T_RAM;
        if (a >= 32'h8000_0000 && a < 32'h8001_0000) return T_IO;
`ifdef DBUS_DECERR_EN
        return T_ERR;
`else
        return T_IO;
`endif
    endfunction

    function automatic logic [31:0] ram_val(input int seq, input logic [11:0] wa);
        return {8'hA5, seq[11:0], wa};
    endfunction

    function automatic logic [31:0] io_val(input int seq, input logic [15:0] a);
        return {seq[15:0] ^ 16'h5A5A, a};
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1:    return {18'd0, 14'($urandom_range(0, 16383))};
            2:       return 32'h0000_3FFC;
            3, 4:    return 32'h8000_0000 | 32'($urandom_range(0, 65535));
            5:       return 32'h8000_FFFC;
            6:       return 32'h0000_4000;
            7:       return 32'h4000_0000;
            8:       return 32'h8001_0000;
            default: return 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic clear_model();
        pq_tgt.delete(); pq_dat.delete();
        rq_d.delete(); rq_w.delete(); iq_d.delete(); iq_w.delete();
        err_due = 0; dec_err_exp = 0; r_pop = 0; i_pop = 0; mst_busy = 0;
        last_tgt = T_RAM;
    endtask

    task automatic drive_random();
        rst_b = 1'b1;
        if ($urandom_range(0, 399) == 0) begin
            rst_b = 1'b0;
            m_bus.req = 1'b0;
            mst_busy = 0;
        end else if (!mst_busy && $urandom_range(0, 1) == 1) begin
            mst_busy = 1;
            m_bus.req   = 1'b1;
            m_bus.write = ($urandom_range(0, 3) == 0);
            m_bus.addr  = rand_addr();
            m_bus.wstrb = 4'($urandom);
            m_bus.wdata = $urandom;
        end else if (!mst_busy) begin
            m_bus.req = 1'b0;
        end
        ram_bus.addr_ok = ($urandom_range(0, 3) != 0);
        io_bus.addr_ok  = ($urandom_range(0, 3) != 0);
        r_pop = 0;
        if (rq_d.size() > 0 && rq_w[0] == 0) begin
            ram_bus.data_ok = 1'b1; ram_bus.rdata = rq_d[0]; r_pop = 1;
        end else begin
            if (rq_d.size() > 0) rq_w[0] = rq_w[0] - 1;
            ram_bus.data_ok = (rq_d.size() == 0) && ($urandom_range(0, 7) == 0);
            ram_bus.rdata = $urandom;
        end
        i_pop = 0;
        if (iq_d.size() > 0 && iq_w[0] == 0) begin
            io_bus.data_ok = 1'b1; io_bus.rdata = iq_d[0]; i_pop = 1;
        end else begin
            if (iq_d.size() > 0) iq_w[0] = iq_w[0] - 1;
            io_bus.data_ok = (iq_d.size() == 0) && ($urandom_range(0, 7) == 0);
            io_bus.rdata = $urandom;
        end
    endtask

    // Compare the DUT against the model, then advance the model past the coming edge.
    task automatic check_and_update();
        int n, d;
        bit ret_e, stall_e, sok, aok_e, nxt_err;
        logic [31:0] dat;
        if (!rst_b) begin
            clear_model();
            return;
        end
        n = pq_tgt.size();
        d = region(m_bus.addr);
        if (n == 0)              ret_e = 0;
        else if (last_tgt == T_RAM) ret_e = ram_bus.data_ok;
        else if (last_tgt == T_IO)  ret_e = io_bus.data_ok;
        else                     ret_e = err_due;
        stall_e = m_bus.req && ((n > 0 && d != last_tgt) || (!m_bus.write && n == MAX_OUT && !ret_e));
        sok = (d == T_RAM) ? ram_bus.addr_ok : (d == T_IO) ? io_bus.addr_ok : 1'b1;
        aok_e = sok && !stall_e;

        if (m_bus.req) chk("m_addr_ok", 32'(m_bus.addr_ok), 32'(aok_e));
        chk("ram_req", 32'(ram_bus.req), 32'(m_bus.req && d == T_RAM && !stall_e));
        chk("io_req", 32'(io_bus.req), 32'(m_bus.req && d == T_IO && !stall_e));
        if (m_bus.req && d == T_RAM) chk("ram_addr", 32'(ram_bus.addr), 32'(m_bus.addr[13:2]));
        if (m_bus.req && d == T_IO) chk("io_addr", 32'(io_bus.addr), 32'(m_bus.addr[15:0]));
        chk("ram_ctl", 32'({ram_bus.write, ram_bus.wstrb}), 32'({m_bus.write, m_bus.wstrb}));
        chk("io_ctl", 32'({io_bus.write, io_bus.wstrb}), 32'({m_bus.write, m_bus.wstrb}));
        chk("ram_wdata", ram_bus.wdata, m_bus.wdata);
        chk("io_wdata", io_bus.wdata, m_bus.wdata);
        chk("m_data_ok", 32'(m_bus.data_ok), 32'(ret_e));
        if (ret_e) chk("m_rdata", m_bus.rdata, pq_dat[0]);
`ifdef DBUS_DECERR_EN
        chk("dec_err", 32'(dec_err), 32'(dec_err_exp));
`endif

        dec_err_exp = m_bus.req && aok_e && d == T_ERR;
        nxt_err = 0;
        if (ret_e) begin
            void'(pq_tgt.pop_front());
            void'(pq_dat.pop_front());
        end
        if (m_bus.req && aok_e && !m_bus.write) begin
            if (d == T_RAM) begin
                dat = ram_val(m_ram_seq, m_bus.addr[13:2]);
                m_ram_seq++;
            end else if (d == T_IO) begin
                dat = io_val(m_io_seq, m_bus.addr[15:0]);
                m_io_seq++;
            end else begin
                dat = 32'hDEAD_BEEF;
                nxt_err = 1;
            end
            pq_tgt.push_back(d);
            pq_dat.push_back(dat);
            last_tgt = d;
        end
        err_due = nxt_err;
        if (m_bus.req && m_bus.addr_ok) mst_busy = 0;

        if (r_pop) begin void'(rq_d.pop_front()); void'(rq_w.pop_front()); end
        if (i_pop) begin void'(iq_d.pop_front()); void'(iq_w.pop_front()); end
        if (ram_bus.req && ram_bus.addr_ok && !ram_bus.write) begin
            rq_d.push_back(ram_val(s_ram_seq, ram_bus.addr));
            rq_w.push_back($urandom_range(0, 4));
            s_ram_seq++;
        end
        if (io_bus.req && io_bus.addr_ok && !io_bus.write) begin
            iq_d.push_back(io_val(s_io_seq, io_bus.addr));
            iq_w.push_back($urandom_range(0, 4));
            s_io_seq++;
        end
    endtask

    task automatic mreq(input bit wr, input logic [31:0] a);
        m_bus.req = 1'b1; m_bus.write = wr; m_bus.addr = a;
    endtask

    initial begin
        rst_b = 1'b0;
        m_bus.req = 0; m_bus.write = 0; m_bus.wstrb = 0; m_bus.addr = 0; m_bus.wdata = 0;
        ram_bus.addr_ok = 0; ram_bus.data_ok = 0; ram_bus.rdata = 0;
        io_bus.addr_ok = 0; io_bus.data_ok = 0; io_bus.rdata = 0;
        m_ram_seq = 0; m_io_seq = 0; s_ram_seq = 0; s_io_seq = 0;
        clear_model();

        // reset state, stale return ignored
        repeat (2) @(posedge clk);
        #1; ram_bus.data_ok = 1;
        @(negedge clk);
        chk("rst_data_ok", 32'(m_bus.data_ok), 32'd0);
        chk("rst_ram_req", 32'(ram_bus.req), 32'd0);
        chk("rst_io_req", 32'(io_bus.req), 32'd0);

        // RAM read 0x10
        next(); rst_b = 1; ram_bus.data_ok = 0; mreq(0, 32'h0000_0010); ram_bus.addr_ok = 1;
        @(negedge clk);
        chk("rd_ram_req", 32'(ram_bus.req), 32'd1);
        chk("rd_ram_addr", 32'(ram_bus.addr), 32'd4);
        chk("rd_addr_ok", 32'(m_bus.addr_ok), 32'd1);
        next(); m_bus.req = 0; ram_bus.addr_ok = 0; ram_bus.data_ok = 1; ram_bus.rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rd_data_ok", 32'(m_bus.data_ok), 32'd1);
        chk("rd_rdata", m_bus.rdata, 32'h1234_5678);
        next(); ram_bus.data_ok = 0;
        @(negedge clk);
        chk("rd_done", 32'(m_bus.data_ok), 32'd0);

        // MMIO write
        next(); mreq(1, 32'h8000_0004); m_bus.wstrb = 4'b0011; m_bus.wdata = 32'h0BAD_F00D; io_bus.addr_ok = 1;
        @(negedge clk);
        chk("wr_io_req", 32'(io_bus.req), 32'd1);
        chk("wr_io_addr", 32'(io_bus.addr), 32'd4);
        chk("wr_io_wstrb", 32'(io_bus.wstrb), 32'd3);
        chk("wr_ram_req", 32'(ram_bus.req), 32'd0);
        next(); m_bus.req = 0; io_bus.addr_ok = 0;
        @(negedge clk);
        chk("wr_no_data_ok", 32'(m_bus.data_ok), 32'd0);

        // RAM read then MMIO read stalls until the RAM return has drained
        next(); mreq(0, 32'h0000_0020); ram_bus.addr_ok = 1;
        @(negedge clk);
        chk("x_first_ok", 32'(m_bus.addr_ok), 32'd1);
        next(); mreq(0, 32'h8000_0008); ram_bus.addr_ok = 0; io_bus.addr_ok = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("x_stall_ok", 32'(m_bus.addr_ok), 32'd0);
            chk("x_stall_io_req", 32'(io_bus.req), 32'd0);
            next();
        end
        ram_bus.data_ok = 1; ram_bus.rdata = 32'h1111_2222;
        @(negedge clk);
        chk("x_ret", 32'(m_bus.data_ok), 32'd1);
        chk("x_ret_data", m_bus.rdata, 32'h1111_2222);
        chk("x_ret_stall", 32'(m_bus.addr_ok), 32'd0);
        next(); ram_bus.data_ok = 0;
        @(negedge clk);
        chk("x_io_ok", 32'(m_bus.addr_ok), 32'd1);
        chk("x_io_req", 32'(io_bus.req), 32'd1);
        chk("x_io_addr", 32'(io_bus.addr), 32'd8);
        next(); m_bus.req = 0; io_bus.addr_ok = 0; io_bus.data_ok = 1; io_bus.rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("x_io_ret", 32'(m_bus.data_ok), 32'd1);
        chk("x_io_data", m_bus.rdata, 32'hCAFE_0001);
        next(); io_bus.data_ok = 0;

        // outstanding limit
        mreq(0, 32'h0000_0030); ram_bus.addr_ok = 1;
        @(negedge clk); chk("lim_1", 32'(m_bus.addr_ok), 32'd1);
        next(); mreq(0, 32'h0000_0034);
        @(negedge clk); chk("lim_2", 32'(m_bus.addr_ok), 32'd1);
        next(); mreq(0, 32'h0000_0038);
        @(negedge clk); chk("lim_3_stall", 32'(m_bus.addr_ok), 32'd0);
        next(); ram_bus.data_ok = 1; ram_bus.rdata = 32'hAAAA_0030;
        @(negedge clk);
        chk("lim_3_ok", 32'(m_bus.addr_ok), 32'd1);
        chk("lim_ret", 32'(m_bus.data_ok), 32'd1);
        chk("lim_ret_data", m_bus.rdata, 32'hAAAA_0030);
        next(); ram_bus.data_ok = 0; mreq(0, 32'h0000_003C);
        @(negedge clk); chk("lim_still_full", 32'(m_bus.addr_ok), 32'd0);

        // reset with two reads pending
        next(); m_bus.req = 0; ram_bus.addr_ok = 0; rst_b = 0;
        next(); rst_b = 1; ram_bus.data_ok = 1; ram_bus.rdata = 32'hBAD0_0000;
        @(negedge clk); chk("rst_late_ret", 32'(m_bus.data_ok), 32'd0);
        next(); ram_bus.data_ok = 0; mreq(0, 32'h0000_0040); ram_bus.addr_ok = 1;
        @(negedge clk); chk("rst_cnt0_ok", 32'(m_bus.addr_ok), 32'd1);
        next(); m_bus.req = 0; ram_bus.addr_ok = 0; ram_bus.data_ok = 1; ram_bus.rdata = 32'h4040_4040;
        @(negedge clk);
        chk("rst_new_ret", 32'(m_bus.data_ok), 32'd1);
        chk("rst_new_data", m_bus.rdata, 32'h4040_4040);
        next(); ram_bus.data_ok = 0;

        // unmapped read
        mreq(0, 32'h4000_0000);
`ifdef DBUS_DECERR_EN
        @(negedge clk);
        chk("um_ok", 32'(m_bus.addr_ok), 32'd1);
        chk("um_ram_req", 32'(ram_bus.req), 32'd0);
        chk("um_io_req", 32'(io_bus.req), 32'd0);
        next(); m_bus.req = 0;
        @(negedge clk);
        chk("um_dec_err", 32'(dec_err), 32'd1);
        chk("um_data_ok", 32'(m_bus.data_ok), 32'd1);
        chk("um_rdata", m_bus.rdata, 32'hDEAD_BEEF);
        next();
        @(negedge clk);
        chk("um_dec_err_end", 32'(dec_err), 32'd0);
        chk("um_ret_end", 32'(m_bus.data_ok), 32'd0);
`else
        io_bus.addr_ok = 1;
        @(negedge clk);
        chk("um_io_req", 32'(io_bus.req), 32'd1);
        chk("um_io_addr", 32'(io_bus.addr), 32'd0);
        chk("um_ok", 32'(m_bus.addr_ok), 32'd1);
        next(); m_bus.req = 0; io_bus.addr_ok = 0; io_bus.data_ok = 1; io_bus.rdata = 32'h7777_0000;
        @(negedge clk);
        chk("um_data_ok", 32'(m_bus.data_ok), 32'd1);
        chk("um_rdata", m_bus.rdata, 32'h7777_0000);
        next(); io_bus.data_ok = 0;
`endif

        // randomized traffic against the model
        next(); rst_b = 0; m_bus.req = 0; ram_bus.data_ok = 0; io_bus.data_ok = 0;
        @(negedge clk);
        check_and_update();
        for (int i = 0; i < 6000; i++) begin
            next();
            drive_random();
            @(negedge clk);
            check_and_update();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
